// File: rtl/demux_16_pkg.sv
// ----------------------------------------------------------------------------
// demux_16_pkg
//   Shared definitions for the 16-way one-hot lane mux/demux pair.
//   - PORT_NUM      : number of lanes
//   - IDX_W         : width of a binary lane index
//   - CNT_W         : width of the drop counter
//   - lane_mask_t   : one-hot lane select / per-lane flag vector
//   - is_onehot     : true when exactly one bit of a lane mask is set
//   - onehot_to_idx : binary index of the set bit of a one-hot lane mask
// ----------------------------------------------------------------------------
package demux_16_pkg;

    localparam int PORT_NUM = 16;
    localparam int IDX_W    = $clog2(PORT_NUM);
    localparam int CNT_W    = 16;

    typedef logic [PORT_NUM-1:0] lane_mask_t;
    typedef logic [IDX_W-1:0]    lane_idx_t;

    // v & (v - 1) clears the lowest set bit; zero afterwards means at most one bit.
    function automatic logic is_onehot(input lane_mask_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // OR-reduction of the indices of the set bits; exact only for one-hot input.
    function automatic lane_idx_t onehot_to_idx(input lane_mask_t v);
        lane_idx_t idx;
        idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (v[i]) begin
                idx = idx | lane_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_16_if.sv
// ----------------------------------------------------------------------------
// demux_16_if
//   Bundle of the input stream and the 16 output lanes of demux_16.
//   Upstream side : in_vld, in_dest (one-hot), in_data -> in_rdy
//   Lane side     : out_vld[i], out_data[i] -> out_rdy[i]
//   Status        : drop (pulse), drop_cnt (saturating count)
//   slave modport is the demux itself; master modport is its environment.
// ----------------------------------------------------------------------------
interface demux_16_if #(
    parameter int DATA_WIDTH = 16
);
    import demux_16_pkg::*;

    logic                  in_vld;
    lane_mask_t            in_dest;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_rdy;

    lane_mask_t            out_vld;
    logic [DATA_WIDTH-1:0] out_data [PORT_NUM-1:0];
    lane_mask_t            out_rdy;

    logic                  drop;
    logic [CNT_W-1:0]      drop_cnt;

    modport slave (
        input  in_vld, in_dest, in_data, out_rdy,
        output in_rdy, out_vld, out_data, drop, drop_cnt
    );

    modport master (
        output in_vld, in_dest, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, drop, drop_cnt
    );

endinterface

// File: rtl/demux_16_lane.sv
// ----------------------------------------------------------------------------
// demux_lane
//   One-entry holding register for a single output lane.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears valid and data
//   load_i  : capture data_i this edge (wins over pop_i)
//   pop_i   : sink takes the held word this edge
//   data_i  : word to capture
//   vld_o   : lane holds a word
//   data_o  : held word (kept unchanged while not loaded)
// ----------------------------------------------------------------------------
module demux_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A load in the same cycle as a pop refills the slot without a bubble.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (pop_i) begin
            vld_d = 1'b0;
        end
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/demux_16.sv
// ----------------------------------------------------------------------------
// demux_16
//   Distributes a one-hot-tagged word stream onto 16 one-entry output lanes
//   with per-lane valid/ready. Words with a malformed destination (zero or
//   several bits set) are consumed without stalling and counted.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_16_if.slave
//           in_vld/in_dest/in_data/in_rdy  - input stream
//           out_vld/out_data/out_rdy       - 16 output lanes
//           drop                           - pulse, malformed word consumed last cycle
//           drop_cnt                       - saturating malformed-word count
// ----------------------------------------------------------------------------
module demux_16
    import demux_16_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    demux_16_if.slave   bus
);

    logic                  dest_ok;
    lane_idx_t             dest_idx;
    logic                  rdy;
    logic                  accept;
    lane_mask_t            load;
    lane_mask_t            pop;
    lane_mask_t            lane_vld;
    logic [DATA_WIDTH-1:0] lane_data [PORT_NUM-1:0];

    logic                  drop_q, drop_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    assign dest_ok  = is_onehot(bus.in_dest);
    assign dest_idx = onehot_to_idx(bus.in_dest);

    // Ready depends only on destination and lane state, never on in_vld.
    // Malformed destinations are always ready so they cannot block the stream.
    assign rdy    = dest_ok ? (~lane_vld[dest_idx] | bus.out_rdy[dest_idx]) : 1'b1;
    assign accept = bus.in_vld & rdy;

    // in_dest is one-hot whenever dest_ok holds, so it doubles as the load decode.
    assign load = (accept && dest_ok) ? bus.in_dest : '0;
    assign pop  = lane_vld & bus.out_rdy;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_lane
        demux_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load[i]),
            .pop_i  (pop[i]),
            .data_i (bus.in_data),
            .vld_o  (lane_vld[i]),
            .data_o (lane_data[i])
        );
    end

    always_comb begin
        drop_d     = accept & ~dest_ok;
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.in_rdy   = rdy;
    assign bus.out_vld  = lane_vld;
    assign bus.out_data = lane_data;
    assign bus.drop     = drop_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_16.sv
// ----------------------------------------------------------------------------
// tb_demux_16
//   Self-checking bench for demux_16: directed vector table, hand-written
//   corner sequences and random traffic against a behavioural lane model.
// ----------------------------------------------------------------------------
module tb_demux_16;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    demux_16_if #(.DATA_WIDTH(16)) bus ();

    demux_16 #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what each lane holds, plus drop status.
    logic [15:0] m_vld;
    logic [15:0] m_data [16];
    logic        m_drop;
    logic [15:0] m_cnt;

    typedef struct {
        logic        vld;
        logic [15:0] dest;
        logic [15:0] data;
        logic [15:0] ordy;
        logic        exp_rdy;
        logic [15:0] exp_ovld;
        int          lane;
        logic [15:0] exp_ldata;
        logic        exp_drop;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = '0;
        m_drop = 1'b0;
        m_cnt  = '0;
        for (int i = 0; i < 16; i++) m_data[i] = '0;
    endtask

    function automatic logic model_rdy(input logic [15:0] dest, input logic [15:0] ordy);
        if ($countones(dest) != 1) return 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (dest[i]) return !m_vld[i] || ordy[i];
        end
        return 1'b1;
    endfunction

    task automatic set_in(input logic v, input logic [15:0] d, input logic [15:0] w,
                          input logic [15:0] r);
        bus.in_vld  = v;
        bus.in_dest = d;
        bus.in_data = w;
        bus.out_rdy = r;
    endtask

    task automatic check_outputs(input string tag);
        int bad;
        bad = 0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.out_data[i] !== m_data[i]) bad = i;
        end
        chk({tag, " out_vld"}, 32'(bus.out_vld), 32'(m_vld));
        chk({tag, " out_data"}, 32'(bus.out_data[bad]), 32'(m_data[bad]));
        chk({tag, " drop"}, 32'(bus.drop), 32'(m_drop));
        chk({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(m_cnt));
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cycle();
        logic r;
        logic acc;
        #2;
        r = model_rdy(bus.in_dest, bus.out_rdy);
        chk("in_rdy", 32'(bus.in_rdy), 32'(r));
        acc = bus.in_vld && r;
        m_vld = m_vld & ~bus.out_rdy;
        m_drop = 1'b0;
        if (acc) begin
            if ($countones(bus.in_dest) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    if (bus.in_dest[i]) begin
                        m_vld[i]  = 1'b1;
                        m_data[i] = bus.in_data;
                    end
                end
            end else begin
                m_drop = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    // Reset pulled low between edges; effect must be visible without a clock.
    task automatic reset_mid();
        int bad;
        set_in(1'b0, 16'h0000, 16'h0000, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        bad = 0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.out_data[i] !== 16'h0000) bad = i;
        end
        chk("rst out_vld", 32'(bus.out_vld), 32'h0);
        chk("rst out_data", 32'(bus.out_data[bad]), 32'h0);
        chk("rst drop", 32'(bus.drop), 32'h0);
        chk("rst drop_cnt", 32'(bus.drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        tbl[0] = '{1'b1, 16'h0008, 16'hA5A5, 16'h0000, 1'b1, 16'h0008, 3, 16'hA5A5, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 16'h0008, 16'hBEEF, 16'h0000, 1'b0, 16'h0008, 3, 16'hA5A5, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 16'h0008, 16'h0001, 16'h0008, 1'b1, 16'h0008, 3, 16'h0001, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 16'h0008, 16'h0002, 16'h0008, 1'b1, 16'h0008, 3, 16'h0002, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 16'h0008, 16'h0003, 16'h0008, 1'b1, 16'h0008, 3, 16'h0003, 1'b0, 16'd0};
        tbl[5] = '{1'b1, 16'h0008, 16'h0004, 16'h0008, 1'b1, 16'h0008, 3, 16'h0004, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 16'h0008, 16'h0000, 16'h0008, 1'b1, 16'h0000, 3, 16'h0004, 1'b0, 16'd0};
        tbl[7] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b1, 16'h0000, 3, 16'h0004, 1'b1, 16'd1};
        tbl[8] = '{1'b1, 16'h0011, 16'h5678, 16'h0000, 1'b1, 16'h0000, 3, 16'h0004, 1'b1, 16'd2};
        tbl[9] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3, 16'h0004, 1'b0, 16'd2};

        // Power-on reset
        rst_n = 1'b0;
        set_in(1'b0, 16'h0001, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset in_rdy", 32'(bus.in_rdy), 32'h1);

        // Directed table: blocking, streaming, malformed destinations
        for (int k = 0; k < 10; k++) begin
            set_in(tbl[k].vld, tbl[k].dest, tbl[k].data, tbl[k].ordy);
            #1;
            chk("tbl in_rdy", 32'(bus.in_rdy), 32'(tbl[k].exp_rdy));
            cycle();
            chk("tbl out_vld", 32'(bus.out_vld), 32'(tbl[k].exp_ovld));
            chk("tbl lane data", 32'(bus.out_data[tbl[k].lane]), 32'(tbl[k].exp_ldata));
            chk("tbl drop", 32'(bus.drop), 32'(tbl[k].exp_drop));
            chk("tbl drop_cnt", 32'(bus.drop_cnt), 32'(tbl[k].exp_cnt));
        end

        // Fill every lane, then drain all of them in one cycle
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 16'(1 << i), 16'(i), 16'h0000);
            cycle();
        end
        chk("fill out_vld", 32'(bus.out_vld), 32'hFFFF);
        chk("fill lane15", 32'(bus.out_data[15]), 32'h000F);
        set_in(1'b0, 16'h0000, 16'h0000, 16'hFFFF);
        cycle();
        chk("drain out_vld", 32'(bus.out_vld), 32'h0000);

        // Same-cycle pop and load on lane 7
        set_in(1'b1, 16'h0080, 16'h1111, 16'h0000);
        cycle();
        chk("l7 first", 32'(bus.out_data[7]), 32'h1111);
        set_in(1'b1, 16'h0080, 16'h2222, 16'h0080);
        #1;
        chk("l7 in_rdy", 32'(bus.in_rdy), 32'h1);
        cycle();
        chk("l7 out_vld", 32'(bus.out_vld[7]), 32'h1);
        chk("l7 data", 32'(bus.out_data[7]), 32'h2222);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [15:0] d;
            sel = $urandom_range(0, 9);
            if (sel < 7)       d = 16'(1 << $urandom_range(0, 15));
            else if (sel == 7) d = 16'h0000;
            else               d = 16'($urandom);
            set_in(1'($urandom_range(0, 3) != 0), d, 16'($urandom), 16'($urandom));
            cycle();
        end

        // Asynchronous reset with full lanes and drop_cnt = 5
        reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 16'h0000, 16'hDEAD, 16'h0000);
            cycle();
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 16'(1 << i), 16'(16'h100 + i), 16'h0000);
            cycle();
        end
        chk("pre-rst cnt", 32'(bus.drop_cnt), 32'd5);
        chk("pre-rst vld", 32'(bus.out_vld), 32'hFFFF);
        reset_mid();
        set_in(1'b1, 16'h0001, 16'hA5A5, 16'h0000);
        cycle();
        chk("post-rst vld", 32'(bus.out_vld), 32'h0001);
        chk("post-rst data", 32'(bus.out_data[0]), 32'hA5A5);
        set_in(1'b0, 16'h0000, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_16.md
# demux_16

One-to-sixteen distributor: accepts a single word stream tagged with a one-hot destination and delivers each word into a one-entry holding register on the selected output lane, with independent valid/ready backpressure per lane. It is the counterpart of the 16-way one-hot read mux. The mux collapses 16 sources onto one bus; this block fans one bus out to 16 sinks, and uses the same 16-bit one-hot encoding for lane selection. Malformed destinations are dropped and counted.

## Interface

- DATA_WIDTH, 16, width of every data word
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_vld  input  1  input word valid
- in_dest  input  16  one-hot destination lane; bit i selects lane i
- in_data  input  DATA_WIDTH  input word
- in_rdy  output  1  input may be accepted this cycle
- out_vld  output  16  lane i holds a word
- out_data  output  DATA_WIDTH x16 (unpacked [15:0])  lane i held word
- out_rdy  input  16  lane i sink accepts its word this cycle
- drop  output  1  registered pulse: a malformed word was consumed last cycle
- drop_cnt  output  16  saturating count of dropped words

## Operation

- Valid destination: in_dest has exactly one bit set. Invalid destination: zero bits or two or more bits set.
- Lane i state: buf_vld[i], buf_data[i].
- in_rdy rules:
  - Valid dest i: in_rdy = ~buf_vld[i] | out_rdy[i].
  - Invalid dest: in_rdy = 1, so a malformed word never stalls the stream.
- Accept = in_vld & in_rdy.
- Accept with valid dest i: buf_data[i] <= in_data and buf_vld[i] <= 1 at the next edge.
- Accept with invalid dest:
  - No lane changes.
  - drop = 1 for exactly one cycle.
  - drop_cnt increments by 1 and saturates at 16'hFFFF.
- Pop on lane i = out_vld[i] & out_rdy[i]. When there is no load that cycle, buf_vld[i] <= 0. buf_data is kept; it is don't-care while invalid.
- Pop and load on the same lane in the same cycle: the new word is loaded, buf_vld stays 1, and no bubble is inserted.
- All 16 lanes pop independently in the same cycle. At most one lane loads per cycle.
- out_vld = buf_vld. out_data = buf_data.
- Reset values:
  - out_vld = 0
  - every out_data lane = 0
  - drop = 0
  - drop_cnt = 0
  - in_rdy follows its combinational rule; with all lanes empty it is 1.
- Reset asserted mid-operation discards all held words immediately, without waiting for a clock edge.

## Timing

- Latency: a word accepted at edge N is presented on out_vld/out_data from N+1 onward.
- Throughput: one word per cycle to the same lane while out_rdy of that lane is held high. Any lane mix also sustains one word per cycle.
- in_rdy is combinational from in_dest and out_rdy only. It does not depend on in_vld, so there is no loop with upstream logic that waits for in_rdy.
- out_vld and out_data are register outputs. While out_vld[i]=1 and out_rdy[i]=0, out_data[i] must stay stable.
- drop is registered: it asserts the cycle after the malformed accept. Back-to-back malformed accepts hold drop high on consecutive cycles.

## Structure

- Shared package: PORT_NUM=16, the one-hot-check function, and the one-hot-to-index function. The matching mux uses the same package.
- Sub-module demux_lane: the one-entry register slice holding buf_vld/buf_data with load and pop inputs. It is instantiated PORT_NUM times through a generate loop.
- The top level holds:
  - dest validation
  - in_rdy selection
  - per-lane load decode
  - drop/drop_cnt logic

## Test plan

- Reset, then send in_data=16'hA5A5 with in_dest=16'h0008 and out_rdy=0. Required: out_vld=16'h0008 and out_data[3]=16'hA5A5 from the next cycle. A second word to lane 3 sees in_rdy=0, and lane 3 is unchanged.
- Hold out_rdy[3]=1 and stream 16'h0001..16'h0004 to lane 3 on consecutive cycles. Required: in_rdy stays 1, and out_data[3] shows 1, 2, 3, 4 on consecutive cycles with no gap.
- Send in_dest=16'h0000, then 16'h0011. Required: in_rdy=1 both cycles, no out_vld change, drop high for 2 cycles, drop_cnt=2.
- Fill all 16 lanes with value i on lane i, then assert out_rdy=16'hFFFF for one cycle. Required: out_vld goes from 16'hFFFF to 16'h0000 in one cycle.
- Lane 7 holds 16'h1111. In the same cycle, out_rdy[7]=1 and a word 16'h2222 arrives for lane 7. Required: in_rdy=1, out_vld[7] stays 1, and out_data[7]=16'h2222 on the next cycle.
- Assert rst_n low between clock edges while lanes are full and drop_cnt=5. Required: out_vld=0, all out_data lanes=0 and drop_cnt=0 immediately; first accepted word after release appears normally.
